slon5_ktable_streamer: RTL and testbench

//  Transmit side of the slon5 round-constant interface: on start, streams all STAGE_NUM

---
 rtl/slon5_ktable_streamer_pkg.sv | 68 ++++++
 rtl/slon5_ktable_streamer_if.sv | 26 ++
 rtl/slon5_ktable_streamer.sv | 78 +++++++
 tb/tb_slon5_ktable_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slon5_ktable_streamer_pkg.sv
// rtl/slon5_ktable_streamer_pkg.sv - shared sizes, types, round-constant table and shift lookup
package slon5_ktable_streamer_pkg;

  localparam int STAGE_NUM = 64;
  localparam int K_W       = 32;
  localparam int S_W       = 5;
  localparam int IDX_W     = $clog2(STAGE_NUM);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [K_W-1:0]   k_word_t;
  typedef logic [S_W-1:0]   shift_t;
  typedef k_word_t          ktable_t [STAGE_NUM];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(STAGE_NUM - 1);

  // K[i] = floor(abs(sin(i+1)) * 2^32), same values as the reference table
  localparam ktable_t KTABLE = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount: quarter picked by the top two index bits, position by the low two
  function automatic shift_t get_shift(idx_t idx);
    logic [3:0] sel;
    shift_t     s;
    sel = {idx[IDX_W-1 -: 2], idx[1:0]};
    case (sel)
      4'h0: s = 5'd7;
      4'h1: s = 5'd12;
      4'h2: s = 5'd17;
      4'h3: s = 5'd22;
      4'h4: s = 5'd5;
      4'h5: s = 5'd9;
      4'h6: s = 5'd14;
      4'h7: s = 5'd20;
      4'h8: s = 5'd4;
      4'h9: s = 5'd11;
      4'ha: s = 5'd16;
      4'hb: s = 5'd23;
      4'hc: s = 5'd6;
      4'hd: s = 5'd10;
      4'he: s = 5'd15;
      default: s = 5'd21;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/slon5_ktable_streamer_if.sv
// rtl/slon5_ktable_streamer_if.sv - control and beat channel between streamer and consumer
interface slon5_ktable_streamer_if;
  import slon5_ktable_streamer_pkg::*;

  logic    start;
  logic    abort;
  logic    busy;
  logic    done;
  logic    m_valid;
  logic    m_ready;
  k_word_t m_k;
  shift_t  m_s;
  idx_t    m_idx;
  logic    m_last;

  modport master (
    input  start, abort, m_ready,
    output busy, done, m_valid, m_k, m_s, m_idx, m_last
  );

  modport slave (
    output start, abort, m_ready,
    input  busy, done, m_valid, m_k, m_s, m_idx, m_last
  );

endinterface

// File: rtl/slon5_ktable_streamer.sv
// rtl/slon5_ktable_streamer.sv - streams the full round-constant table over a valid/ready channel
module slon5_ktable_streamer
  import slon5_ktable_streamer_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  slon5_ktable_streamer_if.master  bus
);

  state_t state;
  idx_t   next_idx;

  assign next_idx = bus.m_idx + 1'b1;

  // Single FSM: every output is a register loaded from the table on the same edge as the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_k     <= '0;
      bus.m_s     <= '0;
      bus.m_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start && !bus.abort) begin
            state       <= ST_STREAM;
            bus.busy    <= 1'b1;
            bus.m_valid <= 1'b1;
            bus.m_idx   <= '0;
            bus.m_k     <= KTABLE[idx_t'(0)];
            bus.m_s     <= get_shift(idx_t'(0));
            bus.m_last  <= (LAST_IDX == idx_t'(0));
          end
        end
        ST_STREAM: begin
          if (bus.abort) begin
            // Abort wins over a handshake in the same cycle: the beat is dropped
            state       <= ST_IDLE;
            bus.busy    <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
          end else if (bus.m_valid && bus.m_ready) begin
            if (bus.m_idx == LAST_IDX) begin
              state       <= ST_DONE;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.m_valid <= 1'b0;
              bus.m_last  <= 1'b0;
            end else begin
              bus.m_idx  <= next_idx;
              bus.m_k    <= KTABLE[next_idx];
              bus.m_s    <= get_shift(next_idx);
              bus.m_last <= (next_idx == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          // One-cycle done pulse; start and abort are both ignored here
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.m_valid <= 1'b0;
          bus.m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slon5_ktable_streamer.sv
// tb/tb_slon5_ktable_streamer.sv - self-checking bench with a trigonometric reference table
module tb_slon5_ktable_streamer;
  import slon5_ktable_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  slon5_ktable_streamer_if bus();

  slon5_ktable_streamer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [K_W-1:0] ref_k   [STAGE_NUM];
  logic [S_W-1:0] ref_s   [STAGE_NUM];
  logic [K_W-1:0] rx_k    [STAGE_NUM];
  logic [S_W-1:0] rx_s    [STAGE_NUM];
  logic           rx_last [STAGE_NUM];
  int             shift_rule [4][4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    real    r;
    longint v;
    shift_rule = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    for (int i = 0; i < STAGE_NUM; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      v = longint'($floor(r * 4294967296.0));
      ref_k[i] = v[K_W-1:0];
      ref_s[i] = S_W'(shift_rule[i / 16][i % 4]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.m_valid, 0);
    check({tag, "_busy"},  bus.busy,    0);
    check({tag, "_done"},  bus.done,    0);
    check({tag, "_last"},  bus.m_last,  0);
    check({tag, "_k"},     bus.m_k,     0);
    check({tag, "_s"},     bus.m_s,     0);
    check({tag, "_idx"},   bus.m_idx,   0);
  endtask

  task automatic start_stream(input string tag);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_first_valid"}, bus.m_valid, 1);
    check({tag, "_first_idx"},   bus.m_idx,   0);
    check({tag, "_first_busy"},  bus.busy,    1);
  endtask

  // ended: 0 = done pulse seen, 1 = aborted, 2 = reset applied, 3 = cycle budget expired
  task automatic run_stream(input int pct, input int stall_idx, input int stall_len,
                            input int repulse_idx, input int abort_idx, input int rst_idx,
                            output int beats, output int cycles, output int dones,
                            output int ended);
    int             exp_idx   = 0;
    int             stall_cnt = 0;
    bit             prev_stall = 1'b0;
    bit             repulsed  = 1'b0;
    bit             hs;
    logic [K_W-1:0] pk;
    logic [S_W-1:0] ps;
    logic [IDX_W-1:0] pi;
    beats = 0; cycles = 0; dones = 0; ended = 3;
    for (int c = 0; c < 1000; c++) begin
      if (prev_stall) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_k",     bus.m_k,     pk);
        check("stall_s",     bus.m_s,     ps);
        check("stall_idx",   bus.m_idx,   pi);
      end
      if (bus.done) begin
        dones++;
        ended = 0;
        break;
      end
      if (bus.m_valid) begin
        if (exp_idx < STAGE_NUM) begin
          check("beat_idx",  bus.m_idx,  exp_idx);
          check("beat_k",    bus.m_k,    ref_k[exp_idx]);
          check("beat_s",    bus.m_s,    ref_s[exp_idx]);
          check("beat_last", bus.m_last, (exp_idx == STAGE_NUM - 1));
        end else begin
          check("extra_beat", bus.m_valid, 0);
        end
        check("beat_busy", bus.busy, 1);
      end
      if (bus.m_valid && exp_idx == abort_idx) begin
        bus.abort   = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        cycles++;
        ended = 1;
        break;
      end
      if (bus.m_valid && exp_idx == rst_idx) begin
        rst = 1'b1;
        #1;
        ended = 2;
        break;
      end
      if (exp_idx == stall_idx && stall_cnt < stall_len) begin
        bus.m_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.m_ready = ($urandom_range(99) < pct);
      end
      if (!repulsed && bus.m_valid && exp_idx == repulse_idx) begin
        bus.start = 1'b1;
        repulsed  = 1'b1;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      pk = bus.m_k; ps = bus.m_s; pi = bus.m_idx;
      hs = bus.m_valid && bus.m_ready;
      if (hs && exp_idx < STAGE_NUM) begin
        rx_k[exp_idx]    = bus.m_k;
        rx_s[exp_idx]    = bus.m_s;
        rx_last[exp_idx] = bus.m_last;
      end
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      if (hs) begin
        beats++;
        exp_idx++;
      end
    end
    bus.m_ready = 1'b0;
    check("stream_budget", ended == 3, 0);
  endtask

  int beats, cycles, dones, ended;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.m_ready = 1'b0;
    build_model();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // abort alone in IDLE, then start together with abort: neither may launch a stream
    bus.abort = 1'b1;
    @(negedge clk);
    check("idle_abort_valid", bus.m_valid, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_valid", bus.m_valid, 0);
    check("start_abort_busy",  bus.busy,    0);
    @(negedge clk);

    // 1: full-rate stream
    start_stream("t1");
    run_stream(100, -1, 0, -1, -1, -1, beats, cycles, dones, ended);
    check("t1_ended",  ended,  0);
    check("t1_beats",  beats,  STAGE_NUM);
    check("t1_cycles", cycles, STAGE_NUM);
    check("t1_done_busy",  bus.busy,    0);
    check("t1_done_valid", bus.m_valid, 0);
    check("t1_k0",    rx_k[0],  32'hd76aa478);
    check("t1_s0",    rx_s[0],  7);
    check("t1_k63",   rx_k[63], 32'heb86d391);
    check("t1_s63",   rx_s[63], 21);
    check("t1_last63", rx_last[63], 1);
    check("t1_last62", rx_last[62], 0);
    // start during the done cycle is ignored
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t1_done_width",    bus.done,    0);
    check("t1_start_in_done", bus.m_valid, 0);
    @(negedge clk);
    check("t1_idle_valid", bus.m_valid, 0);

    // 2: random back-pressure
    start_stream("t2");
    run_stream(50, -1, 0, -1, -1, -1, beats, cycles, dones, ended);
    check("t2_ended", ended, 0);
    check("t2_beats", beats, STAGE_NUM);
    for (int i = 0; i < STAGE_NUM; i++) begin
      check("t2_table_k", rx_k[i], ref_k[i]);
      check("t2_table_s", rx_s[i], ref_s[i]);
    end
    @(negedge clk);
    check("t2_done_width", bus.done, 0);

    // 3: ten-cycle stall at index 16
    start_stream("t3");
    run_stream(100, 16, 10, -1, -1, -1, beats, cycles, dones, ended);
    check("t3_ended",  ended,  0);
    check("t3_beats",  beats,  STAGE_NUM);
    check("t3_cycles", cycles, STAGE_NUM + 10);
    check("t3_k16",    rx_k[16], 32'hf61e2562);
    check("t3_s16",    rx_s[16], 5);
    @(negedge clk);

    // 4: start re-pulsed mid-stream
    start_stream("t4");
    run_stream(100, -1, 0, 10, -1, -1, beats, cycles, dones, ended);
    check("t4_ended",  ended,  0);
    check("t4_beats",  beats,  STAGE_NUM);
    check("t4_cycles", cycles, STAGE_NUM);
    check("t4_dones",  dones,  1);
    @(negedge clk);
    check("t4_no_second_done",  bus.done,    0);
    check("t4_no_second_valid", bus.m_valid, 0);

    // 5: abort at index 32 with a simultaneous handshake
    start_stream("t5");
    run_stream(100, -1, 0, -1, 32, -1, beats, cycles, dones, ended);
    check("t5_ended", ended, 1);
    check("t5_beats", beats, 32);
    check("t5_valid", bus.m_valid, 0);
    check("t5_busy",  bus.busy,    0);
    check("t5_done",  bus.done,    0);
    @(negedge clk);
    check("t5_done_later", bus.done, 0);
    start_stream("t5r");
    check("t5r_k0", bus.m_k, 32'hd76aa478);
    run_stream(100, -1, 0, -1, -1, -1, beats, cycles, dones, ended);
    check("t5r_beats", beats, STAGE_NUM);
    @(negedge clk);

    // 6: reset at index 40
    start_stream("t6");
    run_stream(100, -1, 0, -1, -1, 40, beats, cycles, dones, ended);
    check("t6_ended", ended, 2);
    check_all_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t6_after");
    start_stream("t6r");
    run_stream(100, -1, 0, -1, -1, -1, beats, cycles, dones, ended);
    check("t6r_ended", ended, 0);
    check("t6r_beats", beats, STAGE_NUM);
    check("t6r_k0",    rx_k[0], 32'hd76aa478);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
